// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder:
// load/store funct3 codes, FSM states, funct3 legality.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic f3_illegal(
    input logic [2:0] f3
  );
    return (f3 == 3'b011) ||
           (f3 == 3'b110) ||
           (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/data placement
// and load byte/half extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    rbyte = rword[{addr_lo, 3'b000} +: 8];
    rhalf = addr_lo[1] ? rword[31:16]
                       : rword[15:0];
  end

  always_comb begin
    wmask     = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    unique case (funct3)
      F3_B: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{rbyte[7]}}, rbyte};
      end
      F3_BU: begin
        rdata_ext = {24'h0, rbyte};
      end
      F3_H: begin
        wmask     = addr_lo[1] ? 4'b1100
                               : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{rhalf[15]}}, rhalf};
      end
      F3_HU: begin
        rdata_ext = {16'h0, rhalf};
      end
      F3_W: begin
        wmask     = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rword;
      end
      default: begin
        wmask     = 4'b0000;
        wdata_sh  = '0;
        rdata_ext = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Data-memory responder with WAIT_CYCLES wait states.
// DMEM_DEBUG_PORT_EN adds a combinational dbg read port.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_data
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          acc_go;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_idx;
  logic          acc_oor;
  logic          acc_mis;
  logic          acc_err;
  logic [3:0]    wmask;
  logic [31:0]   wdata_sh;
  logic [31:0]   rdata_ext;

  assign accept = req_valid &&
                  (state_q == ST_IDLE);

  // Zero wait states access straight off the request
  // at the accept edge; otherwise use latched fields.
  always_comb begin
    acc_we    = we_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_f3    = f3_q;
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_f3    = req_funct3;
    end
  end

  always_comb begin
    acc_go = 1'b0;
    if (WAIT_CYCLES == 0)
      acc_go = accept;
    else
      acc_go = (state_q == ST_WAIT) &&
               (cnt_q == 4'd1);
    acc_go = acc_go && reset;
  end

  always_comb begin
    acc_idx = acc_addr[AW+1:2];
    acc_oor = |(acc_addr >> (AW + 2));
    acc_mis = ((acc_f3[1:0] == 2'b01) &&
               acc_addr[0]) ||
              ((acc_f3[1:0] == 2'b10) &&
               (acc_addr[1:0] != 2'b00));
    acc_err = acc_oor || acc_mis ||
              f3_illegal(acc_f3) ||
              (acc_we && acc_f3[2]);
  end

  dmem_lane_align u_align (
    .addr_lo   (acc_addr[1:0]),
    .funct3    (acc_f3),
    .wdata     (acc_wdata),
    .rword     (mem[acc_idx]),
    .wmask     (wmask),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext)
  );

  // Array deliberately has no reset.
  always_ff @(posedge clk) begin
    if (acc_go && acc_we && !acc_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b])
          mem[acc_idx][8*b +: 8] <=
            wdata_sh[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ?
                    ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      f3_q    <= req_funct3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (acc_go) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || acc_we) ?
                 32'h0 : rdata_ext;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  assign rsp_err   = rsp_valid && err_q;
  assign stall     = ((state_q == ST_IDLE) &&
                      req_valid) ||
                     (state_q == ST_WAIT);

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench: three instances with 1, 3 and 0
// wait states, sharing one clock.
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        rst_n [3];
  logic        rv    [3];
  logic        rw    [3];
  logic [31:0] ra    [3];
  logic [31:0] wd    [3];
  logic [2:0]  f3    [3];
  logic        rdy   [3];
  logic        vo    [3];
  logic [31:0] rd    [3];
  logic        er    [3];
  logic        st    [3];
`ifdef DMEM_DEBUG_PORT_EN
  logic [7:0]  dbg_a [3];
  logic [31:0] dbg_d [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_unit #(
      .DEPTH_WORDS (256),
      .WAIT_CYCLES ((g == 0) ? 1 :
                    ((g == 1) ? 3 : 0))
    ) u_dut (
      .clk        (clk),
      .reset      (rst_n[g]),
      .req_valid  (rv[g]),
      .req_ready  (rdy[g]),
      .req_we     (rw[g]),
      .req_addr   (ra[g]),
      .req_wdata  (wd[g]),
      .req_funct3 (f3[g]),
      .rsp_valid  (vo[g]),
      .rsp_rdata  (rd[g]),
      .rsp_err    (er[g]),
      .stall      (st[g])
`ifdef DMEM_DEBUG_PORT_EN
      ,
      .dbg_addr   (dbg_a[g]),
      .dbg_data   (dbg_d[g])
`endif
    );
  end

  typedef struct packed {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] x;
    logic        e;
  } vec_t;

  logic [31:0] g_rd;
  logic        g_er;
  int          g_lat;
  int          g_stl;

  // One request on instance s; lat counts cycles from
  // accept edge to rsp_valid, stl counts stalled cycles.
  task automatic xact(
    input  int          s,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [2:0]  f,
    output logic [31:0] rdo,
    output logic        ero,
    output int          lat,
    output int          stl
  );
    lat = -1;
    stl = 0;
    rdo = '0;
    ero = 1'b0;
    @(negedge clk);
    rv[s] = 1'b1;
    rw[s] = we;
    ra[s] = a;
    wd[s] = d;
    f3[s] = f;
    #1;
    if (st[s]) stl++;
    @(posedge clk);
    #1;
    rv[s] = 1'b0;
    #1;
    for (int k = 0; k < 20; k++) begin
      if (vo[s]) begin
        lat = k + 1;
        rdo = rd[s];
        ero = er[s];
        break;
      end
      if (st[s]) stl++;
      @(posedge clk);
      #2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      n_chk++;
      if (rdy[s] !== 1'b1 || vo[s] !== 1'b0 ||
          rd[s] !== 32'h0 || er[s] !== 1'b0 ||
          st[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: rdy=%b vo=%b rd=%h er=%b st=%b expected 1 0 0 0 0",
                 s, rdy[s], vo[s], rd[s], er[s], st[s]);
      end
    end
    rv[0] = 1'b1;
    #1;
    n_chk++;
    if (st[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall: got %b expected 1",
               st[0]);
    end
    rv[0] = 1'b0;
    #1;
    n_chk++;
    if (st[0] !== 1'b0 || vo[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: st=%b vo=%b expected 0 0",
               st[0], vo[0]);
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) rst_n[s] = 1'b1;
  endtask

  task automatic test_word();
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    n_chk++;
    if (g_rd !== 32'h0 || g_er !== 1'b0 ||
        g_lat != 2 || g_stl != 2) begin
      n_fail++;
      $display("FAIL sw: rd=%h er=%b lat=%0d stall=%0d expected 0 0 2 2",
               g_rd, g_er, g_lat, g_stl);
    end
    xact(0, 1'b0, 32'h10, 32'h0, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    n_chk++;
    if (g_rd !== 32'hDEADBEEF || g_er !== 1'b0 ||
        g_lat != 2 || g_stl != 2) begin
      n_fail++;
      $display("FAIL lw: rd=%h er=%b lat=%0d stall=%0d expected deadbeef 0 2 2",
               g_rd, g_er, g_lat, g_stl);
    end
  endtask

  task automatic test_subword();
    vec_t tv [9];
    tv = '{
      '{1'b1, 32'h11, 32'h55,   3'b000, 32'h0,        1'b0},
      '{1'b0, 32'h10, 32'h0,    3'b010, 32'hDEAD55EF, 1'b0},
      '{1'b0, 32'h13, 32'h0,    3'b000, 32'hFFFFFFDE, 1'b0},
      '{1'b0, 32'h13, 32'h0,    3'b100, 32'h000000DE, 1'b0},
      '{1'b0, 32'h12, 32'h0,    3'b001, 32'hFFFFDEAD, 1'b0},
      '{1'b0, 32'h10, 32'h0,    3'b101, 32'h000055EF, 1'b0},
      '{1'b0, 32'h10, 32'h0,    3'b000, 32'hFFFFFFEF, 1'b0},
      '{1'b1, 32'h12, 32'h1234, 3'b001, 32'h0,        1'b0},
      '{1'b0, 32'h10, 32'h0,    3'b010, 32'h123455EF, 1'b0}
    };
    for (int i = 0; i < 9; i++) begin
      xact(0, tv[i].we, tv[i].a, tv[i].d, tv[i].f,
           g_rd, g_er, g_lat, g_stl);
      n_chk++;
      if (g_rd !== tv[i].x || g_er !== tv[i].e ||
          g_lat != 2 || g_stl != 2) begin
        n_fail++;
        $display("FAIL subword[%0d]: rd=%h er=%b lat=%0d stall=%0d expected %h %b 2 2",
                 i, g_rd, g_er, g_lat, g_stl,
                 tv[i].x, tv[i].e);
      end
    end
  endtask

  task automatic test_errors();
    vec_t tv [7];
    tv = '{
      '{1'b0, 32'h12, 32'h0,      3'b010, 32'h0,        1'b1},
      '{1'b1, 32'h13, 32'hFFFF,   3'b001, 32'h0,        1'b1},
      '{1'b0, 32'h11, 32'h0,      3'b001, 32'h0,        1'b1},
      '{1'b0, 32'h10, 32'h0,      3'b011, 32'h0,        1'b1},
      '{1'b0, 32'h10, 32'h0,      3'b110, 32'h0,        1'b1},
      '{1'b1, 32'h10, 32'h0,      3'b100, 32'h0,        1'b1},
      '{1'b0, 32'h10, 32'h0,      3'b010, 32'h123455EF, 1'b0}
    };
    for (int i = 0; i < 7; i++) begin
      xact(0, tv[i].we, tv[i].a, tv[i].d, tv[i].f,
           g_rd, g_er, g_lat, g_stl);
      n_chk++;
      if (g_rd !== tv[i].x || g_er !== tv[i].e ||
          g_lat != 2 || g_stl != 2) begin
        n_fail++;
        $display("FAIL errors[%0d]: rd=%h er=%b lat=%0d stall=%0d expected %h %b 2 2",
                 i, g_rd, g_er, g_lat, g_stl,
                 tv[i].x, tv[i].e);
      end
    end
  endtask

  task automatic test_range();
    vec_t tv [6];
    tv = '{
      '{1'b1, 32'h0,        32'hA5A5A5A5, 3'b010, 32'h0,        1'b0},
      '{1'b1, 32'h400,      32'hFFFFFFFF, 3'b010, 32'h0,        1'b1},
      '{1'b0, 32'h80000000, 32'h0,        3'b000, 32'h0,        1'b1},
      '{1'b0, 32'h0,        32'h0,        3'b010, 32'hA5A5A5A5, 1'b0},
      '{1'b1, 32'h3FC,      32'h0BADF00D, 3'b010, 32'h0,        1'b0},
      '{1'b0, 32'h3FC,      32'h0,        3'b010, 32'h0BADF00D, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      xact(0, tv[i].we, tv[i].a, tv[i].d, tv[i].f,
           g_rd, g_er, g_lat, g_stl);
      n_chk++;
      if (g_rd !== tv[i].x || g_er !== tv[i].e ||
          g_lat != 2 || g_stl != 2) begin
        n_fail++;
        $display("FAIL range[%0d]: rd=%h er=%b lat=%0d stall=%0d expected %h %b 2 2",
                 i, g_rd, g_er, g_lat, g_stl,
                 tv[i].x, tv[i].e);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    xact(1, 1'b1, 32'h30, 32'h01020304, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    n_chk++;
    if (g_er !== 1'b0 || g_lat != 4 || g_stl != 4) begin
      n_fail++;
      $display("FAIL w3_sw: er=%b lat=%0d stall=%0d expected 0 4 4",
               g_er, g_lat, g_stl);
    end
    @(negedge clk);
    rv[1] = 1'b1;
    rw[1] = 1'b1;
    ra[1] = 32'h30;
    wd[1] = 32'hCAFEF00D;
    f3[1] = 3'b010;
    @(posedge clk);
    #1;
    rv[1] = 1'b0;
    #1;
    n_chk++;
    if (rdy[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL w3_busy: rdy=%b expected 0", rdy[1]);
    end
    @(negedge clk);
    rst_n[1] = 1'b0;
    #1;
    n_chk++;
    if (rdy[1] !== 1'b1 || vo[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL w3_rst_idle: rdy=%b vo=%b expected 1 0",
               rdy[1], vo[1]);
    end
    @(negedge clk);
    rst_n[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vo[1]) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL w3_no_rsp: saw rsp_valid=%b expected 0",
               seen);
    end
    xact(1, 1'b0, 32'h30, 32'h0, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    n_chk++;
    if (g_rd !== 32'h01020304 || g_er !== 1'b0 ||
        g_lat != 4) begin
      n_fail++;
      $display("FAIL w3_kept: rd=%h er=%b lat=%0d expected 01020304 0 4",
               g_rd, g_er, g_lat);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rv[2] = 1'b1;
    rw[2] = 1'b1;
    ra[2] = 32'h40;
    wd[2] = 32'h77777777;
    f3[2] = 3'b010;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_chk++;
      if (rdy[2] !== ((i % 2) == 0) ||
          vo[2] !== ((i % 2) == 1)) begin
        n_fail++;
        $display("FAIL b2b[%0d]: rdy=%b vo=%b expected %b %b",
                 i, rdy[2], vo[2],
                 (i % 2) == 0, (i % 2) == 1);
      end
      @(negedge clk);
    end
    rv[2] = 1'b0;
    @(posedge clk);
    #1;
    xact(2, 1'b0, 32'h40, 32'h0, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    n_chk++;
    if (g_rd !== 32'h77777777 || g_er !== 1'b0 ||
        g_lat != 1 || g_stl != 1) begin
      n_fail++;
      $display("FAIL w0_lw: rd=%h er=%b lat=%0d stall=%0d expected 77777777 0 1 1",
               g_rd, g_er, g_lat, g_stl);
    end
  endtask

`ifdef DMEM_DEBUG_PORT_EN
  task automatic test_debug();
    xact(0, 1'b1, 32'h20, 32'h12345678, 3'b010,
         g_rd, g_er, g_lat, g_stl);
    dbg_a[0] = 8'd8;
    #1;
    n_chk++;
    if (dbg_d[0] !== 32'h12345678) begin
      n_fail++;
      $display("FAIL dbg: got %h expected 12345678",
               dbg_d[0]);
    end
  endtask
`endif

  initial begin
    for (int s = 0; s < 3; s++) begin
      rst_n[s] = 1'b0;
      rv[s]    = 1'b0;
      rw[s]    = 1'b0;
      ra[s]    = '0;
      wd[s]    = '0;
      f3[s]    = '0;
`ifdef DMEM_DEBUG_PORT_EN
      dbg_a[s] = '0;
`endif
    end
    #12;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_range();
    test_mid_reset();
    test_back_to_back();
`ifdef DMEM_DEBUG_PORT_EN
    test_debug();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
